// File: rtl/keypad_array_scan_pkg.sv
// Shared constants and helpers for the multi-pad keypad scanner.
package keypad_pkg;

    // Bit width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int KEY_UP   = 1;
    localparam int KEY_DOWN = 9;
    localparam int DBC_W    = 4;

    typedef enum logic {
        SCAN_IDLE,
        SCAN_RUN
    } scan_state_e;

endpackage

// File: rtl/keypad_array_scan_if.sv
// Keypad matrix bus: column inputs in, row strobes and per-pad key status out.
interface keypad_array_scan_if #(
    parameter int NUM_PADS = 2,
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int KEY_W    = 4
);
    logic [NUM_PADS*COLS-1:0]  cols;
    logic [NUM_PADS*ROWS-1:0]  rows;
    logic [NUM_PADS*KEY_W-1:0] keys;
    logic [NUM_PADS-1:0]       keypressed;
    logic [NUM_PADS-1:0]       key_strobe;

    modport master (input cols, output rows, keys, keypressed, key_strobe);
    modport slave  (output cols, input rows, keys, keypressed, key_strobe);
endinterface

// File: rtl/keypad_array_scan_debounce.sv
// Per-pad frame capture, frame-level debounce and press strobe.
// Auto-repeat strobes are built only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_FRAMES = 250,
    parameter int KEY_W         = 4,
    parameter int RW            = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample,
    input  logic             frame_end,
    input  logic [RW-1:0]    row,
    input  logic [COLS-1:0]  cols,
    output logic [KEY_W-1:0] key_code,
    output logic             key_held,
    output logic             key_strobe
);
    logic             raw_any_q, raw_any_d;
    logic [KEY_W-1:0] raw_code_q, raw_code_d;
    logic             prev_any_q, prev_any_d;
    logic [KEY_W-1:0] prev_code_q, prev_code_d;
    logic [DBC_W-1:0] cnt_q, cnt_d;
    logic             stable_any_q, stable_any_d;
    logic [KEY_W-1:0] stable_code_q, stable_code_d;
    logic             strobe_q, strobe_d;

    logic             hit, cur_any, same, differ, accept;
    logic [KEY_W-1:0] hit_code, cur_code;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = clog2_min1(REPEAT_FRAMES);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    // Scan columns high to low so the lowest low column wins.
    always_comb begin
        hit      = 1'b0;
        hit_code = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!cols[c]) begin
                hit      = 1'b1;
                hit_code = KEY_W'(int'(row) * COLS + c);
            end
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        cur_any       = raw_any_q | (sample & hit);
        cur_code      = raw_any_q ? raw_code_q : ((sample && hit) ? hit_code : '0);
        same          = (cur_any == prev_any_q) && (cur_code == prev_code_q);
        differ        = (cur_any != stable_any_q) || (cur_any && (cur_code != stable_code_q));
        accept        = 1'b0;
        raw_any_d     = raw_any_q;
        raw_code_d    = raw_code_q;
        prev_any_d    = prev_any_q;
        prev_code_d   = prev_code_q;
        cnt_d         = cnt_q;
        stable_any_d  = stable_any_q;
        stable_code_d = stable_code_q;
        strobe_d      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d         = rep_q;
`endif
        if (frame_end) begin
            raw_any_d   = 1'b0;
            raw_code_d  = '0;
            prev_any_d  = cur_any;
            prev_code_d = cur_code;
            if (!same)
                cnt_d = '0;
            else if (cnt_q != DBC_W'(DEBOUNCE - 1))
                cnt_d = cnt_q + 1'b1;
            accept = (cnt_d == DBC_W'(DEBOUNCE - 1)) && differ;
            if (accept) begin
                stable_any_d = cur_any;
                strobe_d     = cur_any;
                // The code is kept after release so keys shows the last key.
                if (cur_any)
                    stable_code_d = cur_code;
            end
`ifdef KEYPAD_REPEAT_EN
            if (accept) begin
                rep_d = '0;
            end else if (stable_any_q) begin
                if (rep_q == REP_W'(REPEAT_FRAMES - 1)) begin
                    rep_d    = '0;
                    strobe_d = 1'b1;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
`endif
        end else if (sample) begin
            raw_any_d  = cur_any;
            raw_code_d = cur_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raw_any_q     <= 1'b0;
            raw_code_q    <= '0;
            prev_any_q    <= 1'b0;
            prev_code_q   <= '0;
            cnt_q         <= '0;
            stable_any_q  <= 1'b0;
            stable_code_q <= '0;
            strobe_q      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q         <= '0;
`endif
        end else begin
            raw_any_q     <= raw_any_d;
            raw_code_q    <= raw_code_d;
            prev_any_q    <= prev_any_d;
            prev_code_q   <= prev_code_d;
            cnt_q         <= cnt_d;
            stable_any_q  <= stable_any_d;
            stable_code_q <= stable_code_d;
            strobe_q      <= strobe_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q         <= rep_d;
`endif
        end
    end

    assign key_code   = stable_code_q;
    assign key_held   = stable_any_q;
    assign key_strobe = strobe_q;
endmodule

// File: rtl/keypad_array_scan.sv
// Shared row-scan engine for NUM_PADS matrix keypads with per-pad debounce.
// Optional auto-repeat strobes: define KEYPAD_REPEAT_EN.
module keypad_array_scan
    import keypad_pkg::*;
#(
    parameter int NUM_PADS      = 2,
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_FRAMES = 250
) (
    input  logic                 CLOCK_50,
    input  logic                 rst_n,
    keypad_array_scan_if.master  bus
);
    localparam int KEY_W = clog2_min1(ROWS * COLS);
    localparam int RW    = clog2_min1(ROWS);
    localparam int DW    = clog2_min1(SCAN_DIV);

    scan_state_e              state_q, state_d;
    logic [DW-1:0]            div_q, div_d;
    logic [RW-1:0]            row_q, row_d;
    logic [NUM_PADS*COLS-1:0] cols_meta_q, cols_sync_q;
    logic [ROWS-1:0]          row_lo;
    logic [NUM_PADS*ROWS-1:0] rows_drv;
    logic                     sample, frame_end;

    logic [NUM_PADS*KEY_W-1:0] keys_w;
    logic [NUM_PADS-1:0]       held_w, strobe_w;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        row_d     = row_q;
        sample    = 1'b0;
        frame_end = 1'b0;
        rows_drv  = '1;
        for (int r = 0; r < ROWS; r++)
            row_lo[r] = (row_q != RW'(r));
        case (state_q)
            SCAN_IDLE: begin
                state_d = SCAN_RUN;
                div_d   = '0;
                row_d   = '0;
            end
            SCAN_RUN: begin
                rows_drv  = {NUM_PADS{row_lo}};
                sample    = (div_q == DW'(SCAN_DIV - 1));
                frame_end = sample && (row_q == RW'(ROWS - 1));
                if (sample) begin
                    div_d = '0;
                    row_d = frame_end ? '0 : row_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = SCAN_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q     <= SCAN_IDLE;
            div_q       <= '0;
            row_q       <= '0;
            cols_meta_q <= '1;
            cols_sync_q <= '1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            row_q       <= row_d;
            cols_meta_q <= bus.cols;
            cols_sync_q <= cols_meta_q;
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        keypad_debounce #(
            .ROWS          (ROWS),
            .COLS          (COLS),
            .DEBOUNCE      (DEBOUNCE),
            .REPEAT_FRAMES (REPEAT_FRAMES),
            .KEY_W         (KEY_W),
            .RW            (RW)
        ) u_dbc (
            .clk        (CLOCK_50),
            .rst_n      (rst_n),
            .sample     (sample),
            .frame_end  (frame_end),
            .row        (row_q),
            .cols       (cols_sync_q[p*COLS +: COLS]),
            .key_code   (keys_w[p*KEY_W +: KEY_W]),
            .key_held   (held_w[p]),
            .key_strobe (strobe_w[p])
        );
    end

    assign bus.rows       = rows_drv;
    assign bus.keys       = keys_w;
    assign bus.keypressed = held_w;
    assign bus.key_strobe = strobe_w;
endmodule

// File: tb/tb_keypad_array_scan.sv
// Self-checking bench: frame-level keypad model with a strobe scoreboard.
module tb_keypad_array_scan;
    localparam int NP = 2, NR = 4, NC = 4, SD = 4, DB = 2, RF = 3, KW = 4;
    localparam int FRAME = NR * SD;

    typedef struct {
        int pad;
        int code;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] held [NP];
    logic [NP*NC-1:0] cols_model;

    int total = 0;
    int bad = 0;
    exp_t sb[$];

    // Frame-level reference model state
    int hist [NP][$];
    int m_stable [NP];
    int m_code [NP];
    int m_rep [NP];

    keypad_array_scan_if #(.NUM_PADS(NP), .ROWS(NR), .COLS(NC), .KEY_W(KW)) bus ();

    keypad_array_scan #(
        .NUM_PADS(NP), .ROWS(NR), .COLS(NC), .SCAN_DIV(SD),
        .DEBOUNCE(DB), .REPEAT_FRAMES(RF)
    ) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        cols_model = '1;
        for (int p = 0; p < NP; p++)
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++)
                    if (!bus.rows[p*NR + r] && held[p][r*NC + c])
                        cols_model[p*NC + c] = 1'b0;
    end
    assign bus.cols = cols_model;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Strobe monitor: every pulse must match the oldest expected press.
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (bus.key_strobe[p]) begin
                if (sb.size() == 0) begin
                    check("strobe_extra", int'(bus.key_strobe[p]), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("strobe_pad", p, e.pad);
                    check("strobe_code", int'(bus.keys[p*KW +: KW]), e.code);
                end
            end
        end
    end

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            hist[p].delete();
            hist[p].push_back(-1);
            m_stable[p] = -1;
            m_code[p] = 0;
            m_rep[p] = 0;
        end
    endtask

    task automatic model_frame(input int p, input logic [15:0] m);
        int raw;
        bit all_eq;
        bit upd;
        raw = -1;
        for (int k = 15; k >= 0; k--)
            if (m[k]) raw = k;
        hist[p].push_back(raw);
        if (hist[p].size() > DB) void'(hist[p].pop_front());
        all_eq = (hist[p].size() == DB);
        foreach (hist[p][i])
            if (hist[p][i] != raw) all_eq = 1'b0;
        upd = all_eq && (raw != m_stable[p]);
        if (upd) begin
            m_stable[p] = raw;
            m_rep[p] = 0;
            if (raw >= 0) begin
                m_code[p] = raw;
                sb.push_back('{pad: p, code: raw});
            end
        end
`ifdef KEYPAD_REPEAT_EN
        else if (m_stable[p] >= 0) begin
            m_rep[p]++;
            if (m_rep[p] == RF) begin
                m_rep[p] = 0;
                sb.push_back('{pad: p, code: m_code[p]});
            end
        end
`endif
    endtask

    // Runs one scan frame starting just after its first edge.
    task automatic run_frame(input logic [15:0] m0, input logic [15:0] m1, input bit chk_rows);
        logic [3:0] pr;
        held[0] = m0;
        held[1] = m1;
        for (int k = 0; k < FRAME; k++) begin
            if (chk_rows) begin
                pr = ~(4'b0001 << (k / SD));
                check("rows_scan", int'(bus.rows), int'({pr, pr}));
            end
            @(posedge clk);
            #1;
        end
        if (chk_rows) check("rows_wrap", int'(bus.rows), 8'hEE);
        check("strobe_missing", sb.size(), 0);
        model_frame(0, m0);
        model_frame(1, m1);
        for (int p = 0; p < NP; p++) begin
            check("keypressed", int'(bus.keypressed[p]), (m_stable[p] >= 0) ? 1 : 0);
            check("keys", int'(bus.keys[p*KW +: KW]), m_code[p]);
        end
    endtask

    task automatic frames(input int n, input logic [15:0] m0, input logic [15:0] m1);
        for (int i = 0; i < n; i++) run_frame(m0, m1, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check("rows_first", int'(bus.rows), 8'hEE);
    endtask

    initial begin
        held[0] = '0;
        held[1] = '0;
        model_reset();

        // Reset and scan order
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_rows", int'(bus.rows), 8'hFF);
        check("rst_keys", int'(bus.keys), 0);
        check("rst_pressed", int'(bus.keypressed), 0);
        check("rst_strobe", int'(bus.key_strobe), 0);
        release_reset();
        run_frame(16'h0000, 16'h0000, 1'b1);
        frames(1, 16'h0000, 16'h0000);

        // Single press on pad 0, key 9, then release
        frames(4, 16'h0200, 16'h0000);
        frames(3, 16'h0000, 16'h0000);

        // Bounce on pad 1, key 5, for a single frame
        frames(1, 16'h0000, 16'h0020);
        frames(3, 16'h0000, 16'h0000);

        // Simultaneous keys 3 and 12, then key 3 released
        frames(3, 16'h1008, 16'h0000);
        frames(3, 16'h1000, 16'h0000);
        frames(3, 16'h0000, 16'h0000);

        // Long hold of key 1 (repeat strobes only with the repeat build)
        frames(12, 16'h0002, 16'h0000);
        frames(3, 16'h0000, 16'h0000);

        // Reset mid-operation while pad 0 holds a stable key
        frames(3, 16'h0200, 16'h0000);
        held[0] = 16'h0200;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_rows", int'(bus.rows), 8'hFF);
        check("mid_rst_keys", int'(bus.keys), 0);
        check("mid_rst_pressed", int'(bus.keypressed), 0);
        check("mid_rst_strobe", int'(bus.key_strobe), 0);
        repeat (3) @(posedge clk);
        release_reset();
        frames(3, 16'h0200, 16'h0000);
        frames(3, 16'h0000, 16'h0000);

        repeat (4) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keypad_array_scan.md
# keypad_array_scan

Parametrised matrix-keypad scanner serving NUM_PADS player keypads from one shared row-scan engine on CLOCK_50. It drives active-low row strobes, synchronises and samples the column inputs, and debounces per pad over whole scan frames. Each pad gets an encoded key code, a held level, and a one-cycle press strobe. It replaces the per-player keypad instances feeding the Pong VGA/game logic, so one block covers any player count and matrix size.

## Interface
Parameters:
- NUM_PADS, 2, number of keypads scanned in lockstep
- ROWS, 4, matrix rows per pad
- COLS, 4, matrix columns per pad
- SCAN_DIV, 50000, clock cycles per row period (1 ms at 50 MHz); minimum 4
- DEBOUNCE, 4, consecutive identical frames required to accept a change; range 1..15
- REPEAT_FRAMES, 250, frames between auto-repeat strobes (used only with KEYPAD_REPEAT_EN)

Ports. One clock; reset is synchronous and active-low.
- CLOCK_50  in  1  system clock; all logic on its rising edge
- rst_n  in  1  synchronous active-low reset
- cols  in  NUM_PADS*COLS  column inputs, active-low with external pull-ups; pad p occupies bits [p*COLS +: COLS]
- rows  out  NUM_PADS*ROWS  row drives, active-low, one row low at a time; all pads driven identically
- keys  out  NUM_PADS*KEY_W  debounced key code per pad, code = row*COLS + col
- keypressed  out  NUM_PADS  debounced "a key is held" level per pad
- key_strobe  out  NUM_PADS  one-cycle pulse per accepted press

KEY_W = $clog2(ROWS*COLS), minimum 1.

## Operation
- Input sync: cols passes through a 2-flop synchroniser before any use.
- Row FSM: the state is the row index r, 0..ROWS-1, and a divider counter 0..SCAN_DIV-1.
  - Row r is driven low for SCAN_DIV cycles.
  - Columns are sampled on the last cycle of the period (divider = SCAN_DIV-1).
  - r then advances and wraps ROWS-1 → 0. The wrap marks end of frame.
- Frame capture, per pad:
  - Within a frame, the first low column found wins. Priority is lowest row first, then lowest column.
  - This gives raw_any and raw_code. Multiple simultaneous keys resolve to the lowest code and are never an error.
- Debounce, per pad, evaluated at end of frame:
  - If (raw_any, raw_code) equals the previous frame's value, a saturating counter increments; otherwise the counter is cleared.
  - When the counter reaches DEBOUNCE-1 and the raw value differs from the stable value, the stable value is updated.
  - keypressed = stable_any. keys = stable_code, and holds its last value after release.
- Strobe: key_strobe[p] pulses for exactly one cycle when stable goes from not-pressed to pressed, or from pressed code A to pressed code B.
  - No pulse on release.
- Reset mid-scan: all state is cleared on the next edge and the scan restarts at row 0. A partial frame is discarded.

## Timing
- Reset values: rows all ones, keys 0, keypressed 0, key_strobe 0. Divider, row index and debounce counters are 0.
- First cycle after rst_n rises: rows bit for row 0 of every pad is low.
- Frame length: ROWS*SCAN_DIV cycles.
- keypressed and key_strobe update in the cycle after the end-of-frame sample.
- Press-to-strobe latency, measured from the first frame in which the key is fully held: DEBOUNCE frames, plus 1 cycle register.
- The synchroniser adds 2 cycles. A key must be stable at least 2 cycles before the sample edge to be captured.
- Press, release and code change are all accepted only after DEBOUNCE identical frames. A glitch shorter than that is ignored.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - While keypressed[p] is held with an unchanged code, key_strobe[p] re-pulses every REPEAT_FRAMES frames after the initial press strobe.
  - The repeat counter resets on any stable change.
- KEYPAD_REPEAT_EN undefined: exactly one strobe per accepted press. REPEAT_FRAMES is ignored and no repeat counter is built.

## Structure
- Package keypad_pkg holds:
  - the KEY_W computation function;
  - key-code constants for the paddle up/down keys (KEY_UP = 1, KEY_DOWN = 9 for a 4x4 pad);
  - the debounce counter width constant.
- Sub-module keypad_debounce, one instance per pad via generate, holds:
  - raw capture;
  - previous-frame register;
  - counter;
  - stable register;
  - strobe logic;
  - the optional repeat counter.
- The row FSM, divider and synchroniser live in keypad_array_scan and are shared by all pads.

## Test plan
Bench parameters: NUM_PADS=2, ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=2, REPEAT_FRAMES=3. A model keypad drives cols low when its row is low and its key is held.

1. Reset and scan order: hold rst_n low 5 cycles, then release → rows = 8'hFF during reset. Pad rows step 1110, 1101, 1011, 0111, changing every 4 cycles with the wrap to 1110. keys = 0, keypressed = 0 throughout.
2. Single press, pad 0, key row 2 col 1 held continuously → keypressed[0] = 1 and keys[0] = 9. key_strobe[0] pulses once, about 2 frames after the first full frame. Pad 1 outputs stay 0.
3. Bounce rejection: pad 1 key 5 held for 1 frame, then released → no strobe, keypressed[1] stays 0.
4. Simultaneous keys: pad 0 holds keys 3 and 12 → keys[0] = 3. Releasing key 3 while 12 stays held → keys[0] = 12 after 2 frames, with a second strobe.
5. Reset mid-operation: assert rst_n low while pad 0 is pressed and stable → all outputs return to reset values on the next edge. Re-acquisition after release of reset yields a fresh strobe.
6. Repeat, with KEYPAD_REPEAT_EN: hold key 1 for 12 frames → initial strobe, then a strobe every 3 frames. Without the macro → exactly one strobe.
